// File: rtl/ip_uart_rx.sv
// 8N1 UART receiver on the cZ80 I/O bus: 16x oversampled line, start/stop
// validation, 4-entry receive FIFO, DATA and STATUS ports at io_address.
module ip_uart_rx #(
  parameter int          clk_freq   = 43750000,
  parameter int          uart_freq  = 115200,
  parameter logic [7:0]  io_address = 8'h10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] bus_address,
  input  logic       bus_ioreq,
  input  logic       bus_write,
  input  logic       bus_valid,
  output logic       bus_ready,
  input  logic [7:0] bus_wdata,
  output logic [7:0] bus_rdata,
  output logic       bus_rdata_en,
  input  logic       uart_rx,
  output logic       rx_ready
);

  localparam int DIV = (clk_freq + uart_freq * 8) / (uart_freq * 16);
  localparam int TW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [TW-1:0] TICK_MAX = TW'(DIV - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_STOP, S_WAIT_HIGH
  } state_t;

  state_t        r_state;
  logic          r_sync1, r_sync2;
  logic [TW-1:0] r_tcnt;
  logic [3:0]    r_sc;
  logic [2:0]    r_bit_idx;
  logic [7:0]    r_shift;

  logic [7:0]    r_mem [0:3];
  logic [1:0]    r_wptr, r_rptr;
  logic [2:0]    r_count;
  logic          r_ferr, r_ovr;
  logic [7:0]    r_rdata;
  logic          r_rdata_en;

  logic w_rxs, w_tick, w_push, w_ferr_set;
  logic w_sel, w_accept, w_rd_data, w_rd_stat, w_wr_stat;
  logic w_empty, w_full, w_pop, w_do_push, w_ovr_set, w_busy;
  logic [7:0] w_status;
  logic w_unused;

  assign w_rxs      = r_sync2;
  assign w_tick     = (r_tcnt == TICK_MAX);
  assign w_push     = (r_state == S_STOP) && w_tick && (r_sc == 4'd15) && w_rxs;
  assign w_ferr_set = (r_state == S_STOP) && w_tick && (r_sc == 4'd15) && !w_rxs;

  assign w_sel     = bus_ioreq && (bus_address[7:1] == io_address[7:1]);
  assign bus_ready = w_sel && !reset;
  assign w_accept  = bus_valid && bus_ready;
  assign w_rd_data = w_accept && !bus_write && !bus_address[0];
  assign w_rd_stat = w_accept && !bus_write &&  bus_address[0];
  assign w_wr_stat = w_accept &&  bus_write &&  bus_address[0];

  assign w_empty   = (r_count == 3'd0);
  assign w_full    = (r_count == 3'd4);
  assign w_pop     = w_rd_data && !w_empty;
  // A pop in the same cycle frees the slot the incoming byte needs.
  assign w_do_push = w_push && (!w_full || w_pop);
  assign w_ovr_set = w_push && w_full && !w_pop;
  assign w_busy    = (r_state != S_IDLE);
  assign w_status  = {w_busy, r_count, r_ferr, r_ovr, w_full, !w_empty};

  assign bus_rdata    = r_rdata;
  assign bus_rdata_en = r_rdata_en;
  assign rx_ready     = !w_empty;
  assign w_unused     = ^{bus_wdata[7:4], bus_wdata[1:0]};

  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync1   <= 1'b1;
      r_sync2   <= 1'b1;
      r_tcnt    <= '0;
      r_state   <= S_IDLE;
      r_sc      <= 4'd0;
      r_bit_idx <= 3'd0;
      r_shift   <= 8'h00;
    end else begin
      r_sync1 <= uart_rx;
      r_sync2 <= r_sync1;
      // Restarting the divider on the start edge phase-aligns every sample.
      if ((r_state == S_IDLE && !w_rxs) || w_tick)
        r_tcnt <= '0;
      else
        r_tcnt <= r_tcnt + 1'b1;
      case (r_state)
        S_IDLE: begin
          if (!w_rxs) begin
            r_state <= S_START;
            r_sc    <= 4'd0;
          end
        end
        S_START: begin
          if (w_tick) begin
            if (r_sc == 4'd7) begin
              r_sc      <= 4'd0;
              r_bit_idx <= 3'd0;
              r_state   <= w_rxs ? S_IDLE : S_DATA;
            end else begin
              r_sc <= r_sc + 4'd1;
            end
          end
        end
        S_DATA: begin
          if (w_tick) begin
            r_sc <= r_sc + 4'd1;
            if (r_sc == 4'd15) begin
              r_shift   <= {w_rxs, r_shift[7:1]};
              r_bit_idx <= r_bit_idx + 3'd1;
              if (r_bit_idx == 3'd7)
                r_state <= S_STOP;
            end
          end
        end
        S_STOP: begin
          if (w_tick) begin
            r_sc <= r_sc + 4'd1;
            if (r_sc == 4'd15)
              r_state <= w_rxs ? S_IDLE : S_WAIT_HIGH;
          end
        end
        S_WAIT_HIGH: begin
          if (w_rxs)
            r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push)
      r_mem[r_wptr] <= r_shift;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wptr     <= 2'd0;
      r_rptr     <= 2'd0;
      r_count    <= 3'd0;
      r_ferr     <= 1'b0;
      r_ovr      <= 1'b0;
      r_rdata    <= 8'h00;
      r_rdata_en <= 1'b0;
    end else begin
      if (w_do_push)
        r_wptr <= r_wptr + 2'd1;
      if (w_pop)
        r_rptr <= r_rptr + 2'd1;
      case ({w_do_push, w_pop})
        2'b10:   r_count <= r_count + 3'd1;
        2'b01:   r_count <= r_count - 3'd1;
        default: r_count <= r_count;
      endcase
      if (w_ferr_set)
        r_ferr <= 1'b1;
      else if (w_wr_stat && bus_wdata[3])
        r_ferr <= 1'b0;
      if (w_ovr_set)
        r_ovr <= 1'b1;
      else if (w_wr_stat && bus_wdata[2])
        r_ovr <= 1'b0;
      r_rdata_en <= w_rd_data || w_rd_stat;
      if (w_rd_stat)
        r_rdata <= w_status;
      else if (w_pop)
        r_rdata <= r_mem[r_rptr];
      else
        r_rdata <= 8'h00;
    end
  end

endmodule
